// File: rtl/fetch_issue_intr_pkg.sv
// rtl/fetch_issue_intr_pkg.sv - shared next-PC source encodings for the fetch stage
package fetch_issue_intr_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JALR   = 2'b11
  } pc_sel_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_pc_mux.sv
// rtl/fetch_pc_mux.sv - prioritised fetch-address source select (reset > trap > select)
module fetch_pc_mux
  import fetch_issue_intr_pkg::*;
#(
  parameter int unsigned             ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    reset,
  input  logic                    trap_branch,
  input  logic [1:0]              next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic [ADDRESS_BITS-1:0] trap_target,
  input  logic [ADDRESS_BITS-1:0] next_PC,
  output logic [ADDRESS_BITS-1:0] fetch_address
);

  logic [ADDRESS_BITS-1:0] w_fetch;

  always_comb begin
    w_fetch = next_PC;
    if (reset) begin
      w_fetch = RESET_PC;
    end else if (trap_branch) begin
      w_fetch = trap_target;
    end else begin
      case (pc_sel_e'(next_PC_select))
        PC_BRANCH, PC_JUMP: w_fetch = target_PC;
        // Indirect jumps must land on an even address.
        PC_JALR:            w_fetch = {target_PC[ADDRESS_BITS-1:1], 1'b0};
        default:            w_fetch = next_PC;
      endcase
    end
  end

  assign fetch_address = w_fetch;

endmodule

// File: rtl/fetch_issue_intr.sv
// rtl/fetch_issue_intr.sv - PC register and fetch-address generation with trap redirect
module fetch_issue_intr
  import fetch_issue_intr_pkg::*;
#(
  parameter int unsigned             ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  input  logic                    trap_branch,
  input  logic [ADDRESS_BITS-1:0] trap_target,
  output logic [ADDRESS_BITS-1:0] next_PC,
  output logic [ADDRESS_BITS-1:0] issue_PC,
  output logic [ADDRESS_BITS-1:0] i_mem_read_address,
  input  logic                    scan
);

  logic [ADDRESS_BITS-1:0] r_pc;
  logic [31:0]             r_cycles;
  logic [ADDRESS_BITS-1:0] w_next_pc;
  logic [ADDRESS_BITS-1:0] w_fetch;

  // Link address always derives from the issued PC, wrapping silently.
  assign w_next_pc = r_pc + ADDRESS_BITS'(PC_STEP);

  fetch_pc_mux #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .RESET_PC     (RESET_PC)
  ) u_pc_mux (
    .reset          (reset),
    .trap_branch    (trap_branch),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .trap_target    (trap_target),
    .next_PC        (w_next_pc),
    .fetch_address  (w_fetch)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_cycles <= '0;
    end else begin
      r_pc     <= w_fetch;
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign next_PC            = w_next_pc;
  assign issue_PC           = r_pc;
  assign i_mem_read_address = w_fetch;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (scan) begin
      $display("cycle=%0d issue_PC=%h next_PC=%h i_mem_read_address=%h next_PC_select=%b trap_branch=%b",
               r_cycles, r_pc, w_next_pc, w_fetch, next_PC_select, trap_branch);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue_intr.sv
// tb/tb_fetch_issue_intr.sv - randomized model-checked bench for fetch_issue_intr
module tb_fetch_issue_intr;

  logic        clock;
  logic        reset;
  logic [1:0]  sel;
  logic [31:0] target;
  logic        trap;
  logic [31:0] trap_tgt;
  logic        scan;

  logic [31:0] next0, issue0, fetch0;
  logic [31:0] next1, issue1, fetch1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc0, m_pc1;
  logic        m_valid = 1'b0;

  fetch_issue_intr #(.ADDRESS_BITS(32), .RESET_PC(32'h0)) dut0 (
    .clock(clock), .reset(reset), .next_PC_select(sel), .target_PC(target),
    .trap_branch(trap), .trap_target(trap_tgt), .next_PC(next0),
    .issue_PC(issue0), .i_mem_read_address(fetch0), .scan(scan)
  );

  fetch_issue_intr #(.ADDRESS_BITS(32), .RESET_PC(32'h100)) dut1 (
    .clock(clock), .reset(reset), .next_PC_select(sel), .target_PC(target),
    .trap_branch(trap), .trap_target(trap_tgt), .next_PC(next1),
    .issue_PC(issue1), .i_mem_read_address(fetch1), .scan(scan)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Where the next instruction comes from, straight from the priority rules.
  function automatic logic [31:0] model_fetch(input logic rst, input logic trp, input logic [1:0] s,
                                              input logic [31:0] tgt, input logic [31:0] ttgt,
                                              input logic [31:0] pc, input logic [31:0] rpc);
    if (rst) return rpc;
    if (trp) return ttgt;
    if (s == 2'd0) return pc + 32'd4;
    if (s == 2'd3) return tgt & ~32'd1;
    return tgt;
  endfunction

  always @(posedge clock) begin
    m_pc0   <= model_fetch(reset, trap, sel, target, trap_tgt, m_pc0, 32'h0);
    m_pc1   <= model_fetch(reset, trap, sel, target, trap_tgt, m_pc1, 32'h100);
    m_valid <= m_valid | reset;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("issue_PC0", issue0, m_pc0);
      check("next_PC0", next0, m_pc0 + 32'd4);
      check("fetch0", fetch0, model_fetch(reset, trap, sel, target, trap_tgt, m_pc0, 32'h0));
      check("issue_PC1", issue1, m_pc1);
      check("next_PC1", next1, m_pc1 + 32'd4);
      check("fetch1", fetch1, model_fetch(reset, trap, sel, target, trap_tgt, m_pc1, 32'h100));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; sel = 2'd0; target = '0; trap = 1'b0; trap_tgt = '0; scan = 1'b0;
    repeat (3) tick();
    #2;
    check("reset_issue0", issue0, 32'h0);
    check("reset_next0", next0, 32'h4);
    check("reset_fetch0", fetch0, 32'h0);
    check("reset_issue1", issue1, 32'h100);

    reset = 1'b0;
    tick(); #2; check("seq_4", issue0, 32'h4);  check("seq_fetch_8", fetch0, 32'h8);
    tick(); #2; check("seq_8", issue0, 32'h8);
    tick(); #2; check("seq_12", issue0, 32'hC); check("seq_fetch_16", fetch0, 32'h10);

    sel = 2'b10; target = 32'h8000;
    tick(); #2; check("jump", issue0, 32'h8000);

    sel = 2'b00; trap = 1'b1; trap_tgt = 32'hC0;
    #1;
    check("trap_next", next0, 32'h8004);
    check("trap_fetch", fetch0, 32'hC0);
    tick(); #2; check("trap_issue", issue0, 32'hC0);

    trap = 1'b0; sel = 2'b11; target = 32'h1235;
    tick(); #2; check("jalr", issue0, 32'h1234);
    sel = 2'b01; target = 32'h40;
    tick(); #2; check("branch", issue0, 32'h40);

    sel = 2'b10; target = 32'hFFFF_FFFC;
    tick(); #2; check("pre_wrap", issue0, 32'hFFFF_FFFC); check("wrap_next", next0, 32'h0);
    sel = 2'b00;
    tick(); #2; check("wrap", issue0, 32'h0);

    reset = 1'b1; trap = 1'b1; trap_tgt = 32'hDEAD_BEE0;
    tick(); #2;
    check("reset_trap0", issue0, 32'h0);
    check("reset_trap1", issue1, 32'h100);
    trap = 1'b0; reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 24) == 0);
      trap     = ($urandom_range(0, 5) == 0);
      sel      = 2'($urandom_range(0, 3));
      target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      trap_tgt = $urandom;
      scan     = 1'b0;
      tick();
    end

    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_issue_intr.md
# fetch_issue_intr

Program-counter fetch stage with interrupt/trap redirection for the base in-order core. It holds the PC of the instruction currently issued to decode. It computes the next fetch address from sequential, branch/jump or trap sources and drives it combinationally to the synchronous-read instruction memory. This keeps the returned instruction word aligned with `issue_PC` one cycle later.

## Interface
Parameters:
- `RESET_PC`, default 0: PC value loaded during reset and first address fetched.
- `ADDRESS_BITS`, default 32: width of all address/PC signals.

Ports:
- `clock`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `next_PC_select`  in  2  next-PC source: 00 sequential, 01 branch target, 10 jump target, 11 indirect-jump target with bit 0 cleared.
- `target_PC`  in  ADDRESS_BITS  branch/jump target from execute.
- `trap_branch`  in  1  trap/interrupt redirect request; overrides `next_PC_select`.
- `trap_target`  in  ADDRESS_BITS  trap handler address.
- `next_PC`  out  ADDRESS_BITS  `issue_PC + 4`, the link/return address; never reflects redirects.
- `issue_PC`  out  ADDRESS_BITS  PC of the instruction being issued (registered).
- `i_mem_read_address`  out  ADDRESS_BITS  fetch address to instruction memory (combinational).
- `scan`  in  1  simulation debug enable; no functional effect.

## Operation
- State: one `ADDRESS_BITS` PC register, which drives `issue_PC`, plus a 32-bit cycle counter used only for scan output.
- `next_PC = issue_PC + 4`, computed modulo 2^ADDRESS_BITS so it wraps silently.
- Fetch address priority, highest first:
  - `reset`: `RESET_PC`.
  - `trap_branch`: `trap_target`.
  - `next_PC_select` 01 or 10: `target_PC`.
  - `next_PC_select` 11: `{target_PC[ADDRESS_BITS-1:1], 1'b0}`.
  - `next_PC_select` 00: `next_PC`.
- Each rising edge: PC register <= `i_mem_read_address`.
- While `reset` is high, the PC register stays at `RESET_PC` and the cycle counter clears.
- Trap and select are sampled only at the clock edge; there is no holding or latching of requests.
- When `scan` is high, a simulation-only `$display` prints the cycle count, `issue_PC`, `next_PC`, `i_mem_read_address`, `next_PC_select` and `trap_branch` each cycle. This is excluded from synthesis.

## Timing
- Reset value: `issue_PC = RESET_PC`, `next_PC = RESET_PC + 4`, `i_mem_read_address = RESET_PC`.
- On the first edge after `reset` falls with select 00, `issue_PC = RESET_PC + 4`.
- Redirect latency: 1 cycle. A target or trap presented before edge N appears on `issue_PC` after edge N.
- `i_mem_read_address` and `next_PC` have zero cycles of combinational latency from inputs and the PC register.
- Simultaneous `trap_branch` and any `next_PC_select`: trap wins.
- Simultaneous `reset` and `trap_branch`: reset wins.
- Reset asserted mid-stream: `RESET_PC` is loaded at the next edge.
- There are no stalls or handshakes; the PC advances every cycle.

## Structure
- A shared core package holds the `next_PC_select` encodings: `PC_SEQ=2'b00`, `PC_BRANCH=2'b01`, `PC_JUMP=2'b10`, `PC_JALR=2'b11`.
- The combinational source mux is a natural sub-module, `fetch_pc_mux`, with inputs `reset`, `trap_branch`, select, the targets and `next_PC`, and output the fetch address.
- The top level contains the PC register, the +4 adder, the cycle counter and the scan display.

## Test plan
- Reset 3 cycles with `RESET_PC=0`, then release with select 00. Expect `issue_PC` = 4, 8, 12 on the following edges, and `i_mem_read_address = issue_PC + 4` throughout.
- From `issue_PC=12`, set select 10 with `target_PC=0x8000`. After one edge, `issue_PC=0x8000`.
- With `issue_PC=0x8000`, select 00, `trap_branch=1`, `trap_target=0xC0`:
  - 1 ns later, `next_PC=0x8004` and `i_mem_read_address=0xC0`.
  - After the edge, `issue_PC=0xC0`.
- Select 11 with `target_PC=0x1235`. After one edge, `issue_PC=0x1234`. Select 01 with `target_PC=0x40` gives `issue_PC=0x40`.
- Set PC to `0xFFFFFFFC` via select 10, then select 00. After one edge, `issue_PC=0`, showing wrap-around.
- Assert `reset` together with `trap_branch=1` mid-run. After one edge, `issue_PC=RESET_PC`. Repeat with `RESET_PC=0x100` to confirm the parameter is used.
